branch_resolve_unit: RTL and testbench

//  Parametrised, pipelined successor to the combinational branch comparator.

---
 rtl/bru_pkg.sv | 46 ++++
 rtl/bru_cmp.sv | 22 ++
 rtl/branch_resolve_unit.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: funct3 codes, stage payload types
// and the condition decode helpers.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Only width-independent fields live here; XLEN/PC_W-wide fields travel beside them.
    typedef struct packed {
        logic       eq;
        logic       lt;
        logic [2:0] funct3;
        logic       pred;
    } bru_s1_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic taken;
        logic mispredict;
        logic illegal;
    } bru_res_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    // lt is already the signed or unsigned flag selected by funct3[1].
    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/bru_cmp.sv
// Combinational XLEN-wide comparator producing equal, signed-less-than and
// unsigned-less-than flags.
module bru_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            eq_o,
    output logic            lt_o,
    output logic            ltu_o
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s   = a_i;
    assign b_s   = b_i;
    assign eq_o  = (a_i == b_i);
    assign lt_o  = (a_s < b_s);
    assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined RISC-V conditional branch resolver with valid/ready handshake and flush.
// Optional macro BRU_PERF_CNT_EN adds branch/taken/mispredict performance counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [PC_W-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_eq,
    output logic            br_lt,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic            mispredict,
    output logic            illegal
`ifdef BRU_PERF_CNT_EN
   ,output logic [31:0]     perf_branches,
    output logic [31:0]     perf_taken,
    output logic [31:0]     perf_mispred
`endif
);

    if ((STAGES != 1) && (STAGES != 2)) begin : g_bad_stages
        $error("branch_resolve_unit: STAGES must be 1 or 2");
    end
    if (PC_W > XLEN) begin : g_bad_pcw
        $error("branch_resolve_unit: PC_W must not exceed XLEN");
    end

    logic eq_c, lt_c, ltu_c;

    bru_cmp #(.XLEN(XLEN)) u_cmp (
        .a_i   (rs1),
        .b_i   (rs2),
        .eq_o  (eq_c),
        .lt_o  (lt_c),
        .ltu_o (ltu_c)
    );

    bru_s1_t s1_d;
    assign s1_d = '{eq: eq_c, lt: (funct3[1] ? ltu_c : lt_c), funct3: funct3, pred: pred_taken};

    // Resolve-stage source: the S1 register, or the live request when STAGES == 1.
    logic            rs_vld;
    bru_s1_t         rs_ctl;
    logic [PC_W-1:0] rs_pc;
    logic [PC_W-1:0] rs_imm;
    logic [PC_W-1:0] rs_ptgt;
    logic            out_adv;

    if (STAGES == 2) begin : g_s1
        logic            s1_vld_q;
        bru_s1_t         s1_q;
        logic [PC_W-1:0] s1_pc_q;
        logic [PC_W-1:0] s1_imm_q;
        logic [PC_W-1:0] s1_ptgt_q;
        logic            s1_adv;

        assign s1_adv   = !s1_vld_q || out_adv;
        assign in_ready = !s1_vld_q || s1_adv;

        // ---- S1: compare ----
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_vld_q  <= 1'b0;
                s1_q      <= '0;
                s1_pc_q   <= '0;
                s1_imm_q  <= '0;
                s1_ptgt_q <= '0;
            end else begin
                if (flush) begin
                    s1_vld_q <= 1'b0;
                end else if (s1_adv) begin
                    s1_vld_q <= in_valid;
                end
                if (s1_adv && in_valid && !flush) begin
                    s1_q      <= s1_d;
                    s1_pc_q   <= pc;
                    s1_imm_q  <= imm[PC_W-1:0];
                    s1_ptgt_q <= pred_target;
                end
            end
        end

        assign rs_vld  = s1_vld_q;
        assign rs_ctl  = s1_q;
        assign rs_pc   = s1_pc_q;
        assign rs_imm  = s1_imm_q;
        assign rs_ptgt = s1_ptgt_q;
    end else begin : g_s0
        assign in_ready = out_adv;
        assign rs_vld   = in_valid;
        assign rs_ctl   = s1_d;
        assign rs_pc    = pc;
        assign rs_imm   = imm[PC_W-1:0];
        assign rs_ptgt  = pred_target;
    end

    bru_res_t        res_d;
    logic [PC_W-1:0] tgt_d;

    always_comb begin
        res_d            = '0;
        res_d.eq         = rs_ctl.eq;
        res_d.lt         = rs_ctl.lt;
        res_d.illegal    = f3_illegal(rs_ctl.funct3);
        res_d.taken      = f3_taken(rs_ctl.funct3, rs_ctl.eq, rs_ctl.lt);
        // Both sums wrap modulo 2^PC_W.
        tgt_d            = res_d.taken ? (rs_pc + rs_imm) : (rs_pc + PC_W'(4));
        res_d.mispredict = (res_d.taken != rs_ctl.pred) || (res_d.taken && (rs_ptgt != tgt_d));
    end

    logic            out_vld_q;
    bru_res_t        out_q;
    logic [PC_W-1:0] out_tgt_q;

    assign out_adv = !out_vld_q || out_ready;

    // ---- S2: resolve / output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            out_tgt_q <= '0;
        end else begin
            if (flush) begin
                out_vld_q <= 1'b0;
            end else if (out_adv) begin
                out_vld_q <= rs_vld;
            end
            if (out_adv && rs_vld && !flush) begin
                out_q     <= res_d;
                out_tgt_q <= tgt_d;
            end
        end
    end

    assign out_valid  = out_vld_q;
    assign br_eq      = out_q.eq;
    assign br_lt      = out_q.lt;
    assign taken      = out_q.taken;
    assign target     = out_tgt_q;
    assign mispredict = out_q.mispredict;
    assign illegal    = out_q.illegal;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_tk_q, perf_mp_q;
    logic        out_hs;

    assign out_hs = out_vld_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_tk_q <= '0;
            perf_mp_q <= '0;
        end else if (out_hs) begin
            perf_br_q <= perf_br_q + 32'd1;
            if (out_q.taken)      perf_tk_q <= perf_tk_q + 32'd1;
            if (out_q.mispredict) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign perf_branches = perf_br_q;
    assign perf_taken    = perf_tk_q;
    assign perf_mispred  = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a transaction-level model.
module tb_branch_resolve_unit;

    localparam int XLEN   = 32;
    localparam int PC_W   = 32;
    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, pred_taken, flush, out_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm, pred_target, target;
    logic        br_eq, br_lt, taken, mispredict, illegal;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_taken, perf_mispred;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .PC_W(PC_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .pred_target(pred_target), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .br_eq(br_eq), .br_lt(br_lt), .taken(taken), .target(target),
        .mispredict(mispredict), .illegal(illegal)
`ifdef BRU_PERF_CNT_EN
       ,.perf_branches(perf_branches), .perf_taken(perf_taken), .perf_mispred(perf_mispred)
`endif
    );

    typedef struct {
        logic        eq, lt, tk, mis, ill;
        logic [31:0] tgt;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0, n_err = 0, cyc = 0;
    int          n_pop = 0, run = 0, last_pop_cyc = -10;
    bit          acc_last, seen_block, stall_prev;
    logic [36:0] snap;
    logic        last_lt, last_tk, last_mis, last_ill;
    logic [31:0] last_tgt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Branch semantics straight from the ISA rules.
    function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p, input logic [31:0] i,
                                   input logic pt, input logic [31:0] ptg);
        exp_t e;
        logic slt, ult;
        slt   = ($signed(a) < $signed(b));
        ult   = (a < b);
        e.eq  = (a == b);
        e.lt  = f[1] ? ult : slt;
        e.ill = (f == 3'd2) || (f == 3'd3);
        case (f)
            3'd0: e.tk = (a == b);
            3'd1: e.tk = (a != b);
            3'd4: e.tk = slt;
            3'd5: e.tk = !slt;
            3'd6: e.tk = ult;
            3'd7: e.tk = !ult;
            default: e.tk = 1'b0;
        endcase
        e.tgt = e.tk ? (p + i) : (p + 32'd4);
        e.mis = (e.tk != pt) || (e.tk && (ptg != e.tgt));
        return e;
    endfunction

    task automatic monitor();
        exp_t        e;
        logic [36:0] now_v;
        now_v    = {br_eq, br_lt, taken, mispredict, illegal, target};
        acc_last = 1'b0;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) check("hold_stable", 64'(now_v), 64'(snap));
        if (!in_ready) seen_block = 1'b1;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = q[0];
                check("br_eq", 64'(br_eq), 64'(e.eq));
                check("br_lt", 64'(br_lt), 64'(e.lt));
                check("taken", 64'(taken), 64'(e.tk));
                check("target", 64'(target), 64'(e.tgt));
                check("mispredict", 64'(mispredict), 64'(e.mis));
                check("illegal", 64'(illegal), 64'(e.ill));
                if (out_ready) begin
                    e        = q.pop_front();
                    last_lt  = br_lt;
                    last_tk  = taken;
                    last_mis = mispredict;
                    last_ill = illegal;
                    last_tgt = target;
                    n_pop++;
                    run = (last_pop_cyc == cyc - 1) ? run + 1 : 1;
                    last_pop_cyc = cyc;
                end
            end
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back(model(funct3, rs1, rs2, pc, imm, pred_taken, pred_target));
            acc_last = 1'b1;
        end
        stall_prev = out_valid && !out_ready && !flush;
        snap       = now_v;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [31:0] i,
                           input logic pt, input logic [31:0] ptg);
        funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt; pred_target = ptg;
    endtask

    task automatic rand_req();
        logic [31:0] a, b, r, p;
        a = $urandom;
        case ($urandom % 4)
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            2:       b = a + 32'd1;
            default: b = $urandom;
        endcase
        r = $urandom;
        p = $urandom;
        set_req(3'($urandom), a, b, p, {{19{r[12]}}, r[12:1], 1'b0}, 1'($urandom),
                ($urandom % 2 == 0) ? p + {{19{r[12]}}, r[12:1], 1'b0} : $urandom);
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i,
                        input logic pt, input logic [31:0] ptg);
        set_req(f, a, b, p, i, pt, ptg);
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_last) break;
        end
        check("send_accepted", 64'(acc_last), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && (q.size() != 0 || out_valid); k++) tick();
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_pending", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0, nacc;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({br_eq, br_lt, taken, mispredict, illegal, target}), 64'd0);

        // BEQ equal, predicted not taken: two-cycle latency
        send(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'd0);
        check("lat_early", 64'(out_valid), 64'd0);
        tick();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("t1_taken", 64'(taken), 64'd1);
        check("t1_target", 64'(target), 64'h120);
        check("t1_mispredict", 64'(mispredict), 64'd1);
        drain();

        // signed vs unsigned compare of 0xFFFFFFFF and 1
        send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h80, 1'b0, 32'd0);
        drain();
        check("blt_taken", 64'(last_tk), 64'd1);
        check("blt_lt", 64'(last_lt), 64'd1);
        send(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h80, 1'b0, 32'd0);
        drain();
        check("bltu_taken", 64'(last_tk), 64'd0);
        check("bltu_target", 64'(last_tgt), 64'h404);

        // back-to-back burst of 8
        pops0 = n_pop;
        for (int k = 0; k < 8; k++) begin
            rand_req();
            in_valid = 1'b1;
            tick();
            check("burst_accept", 64'(acc_last), 64'd1);
        end
        drain();
        check("burst_count", 64'(n_pop - pops0), 64'd8);
        check("burst_consecutive", 64'(run), 64'd8);

        // consumer stall with three requests offered
        out_ready = 1'b0; seen_block = 1'b0; pops0 = n_pop; nacc = 0;
        rand_req(); in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (acc_last) begin
                nacc++;
                if (nacc < 3) rand_req(); else in_valid = 1'b0;
            end
        end
        check("stall_in_ready_fell", 64'(seen_block), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && nacc < 3; k++) begin
            tick();
            if (acc_last) begin
                nacc++;
                if (nacc < 3) rand_req(); else in_valid = 1'b0;
            end
        end
        check("stall_accepts", 64'(nacc), 64'd3);
        drain();
        check("stall_pops", 64'(n_pop - pops0), 64'd3);

        // flush two in flight plus a new request
        out_ready = 1'b0; pops0 = n_pop;
        rand_req(); send(funct3, rs1, rs2, pc, imm, pred_taken, pred_target);
        rand_req(); send(funct3, rs1, rs2, pc, imm, pred_taken, pred_target);
        rand_req(); in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("flush_no_out", 64'(out_valid), 64'd0);
            tick();
        end
        check("flush_dropped", 64'(n_pop - pops0), 64'd0);
        send(3'd1, 32'd1, 32'd2, 32'h800, 32'h10, 1'b1, 32'h810);
        drain();
        check("post_flush_result", 64'(n_pop - pops0), 64'd1);

        // illegal funct3 and PC wrap
        send(3'd2, 32'd3, 32'd3, 32'h200, 32'h40, 1'b1, 32'h240);
        drain();
        check("ill_flag", 64'(last_ill), 64'd1);
        check("ill_taken", 64'(last_tk), 64'd0);
        check("ill_mispredict", 64'(last_mis), 64'd1);
        check("ill_target", 64'(last_tgt), 64'h204);
        send(3'd0, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10);
        drain();
        check("wrap_target", 64'(last_tgt), 64'h10);
        check("wrap_mispredict", 64'(last_mis), 64'd0);

        // randomized traffic with flushes and one mid-run reset
        for (int i = 0; i < 400; i++) begin
            rand_req();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 25) == 0;
            if (i == 200) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("midrst_out_valid", 64'(out_valid), 64'd0);
                check("midrst_in_ready", 64'(in_ready), 64'd1);
                check("midrst_target", 64'(target), 64'd0);
            end else begin
                tick();
            end
        end
        flush = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
